// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for a shared FIFO: round-robin between producers, whole
// packets kept contiguous, and a credit counter that blocks writes into a full FIFO.
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_REQ    = 4,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic                          fifo_wr_en,
    input  logic                          fifo_rd_en,
    input  logic                          fifo_empty,
    output logic [CW-1:0]                 credits,
    output logic                          busy,
    output logic                          err_underflow
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                  state_r;
    logic [PW-1:0]           rr_ptr_r;
    logic [PW-1:0]           owner_r;
    logic [CW-1:0]           credits_r;
    logic                    wr_en_r;
    logic [FIFO_WIDTH-1:0]   data_r;
    logic                    err_r;

    logic [PW-1:0]           idx_s;
    logic [PW-1:0]           winner_s;
    logic                    found_s;
    logic [PW-1:0]           grant_idx_s;
    logic                    grant_en_s;
    logic                    accept_s;
    logic                    last_s;
    logic [FIFO_WIDTH-1:0]   beat_s;
    logic                    pop_s;
    logic                    full_credit_s;
    logic                    pop_ok_s;
    logic [PW-1:0]           next_ptr_s;

    // Round-robin scan: first valid producer at or above rr_ptr, wrapping.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        idx_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = PW'((int'(rr_ptr_r) + k) % NUM_REQ);
            if (!found_s && req_valid[idx_s]) begin
                found_s  = 1'b1;
                winner_s = idx_s;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Grant selection, ready generation, accept/pop qualification.
    always_comb begin
        if (state_r == IDLE) begin
            grant_idx_s = winner_s;
            grant_en_s  = found_s && (credits_r != '0);
        end else begin
            grant_idx_s = owner_r;
            grant_en_s  = req_valid[owner_r] && (credits_r != '0);
        end
        // Ready stays low while reset is asserted even if producers are valid.
        accept_s      = grant_en_s && rst_n;
        req_ready     = accept_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s) : '0;
        last_s        = req_last[grant_idx_s];
        beat_s        = req_data[grant_idx_s*FIFO_WIDTH +: FIFO_WIDTH];
        pop_s         = fifo_rd_en && !fifo_empty;
        full_credit_s = (credits_r == CW'(FIFO_DEPTH));
        pop_ok_s      = pop_s && !full_credit_s;
        next_ptr_s    = (grant_idx_s == PW'(NUM_REQ - 1)) ? '0 : grant_idx_s + PW'(1);
    end

    // State, round-robin pointer, credits, write path and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            owner_r   <= '0;
            credits_r <= CW'(FIFO_DEPTH);
            wr_en_r   <= 1'b0;
            data_r    <= '0;
            err_r     <= 1'b0;
        end else begin
            wr_en_r <= accept_s;
            if (accept_s) begin
                data_r <= beat_s;
            end
            case ({accept_s, pop_ok_s})
                2'b10:   credits_r <= credits_r - CW'(1);
                2'b01:   credits_r <= credits_r + CW'(1);
                default: credits_r <= credits_r;
            endcase
            if (pop_s && full_credit_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (last_s) begin
                            rr_ptr_r <= next_ptr_s;
                        end else begin
                            state_r <= LOCKED;
                            owner_r <= grant_idx_s;
                        end
                    end
                end
                LOCKED: begin
                    if (accept_s && last_s) begin
                        state_r  <= IDLE;
                        rr_ptr_r <= next_ptr_s;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign fifo_wr_en    = wr_en_r;
    assign fifo_data_in  = data_r;
    assign credits       = credits_r;
    assign busy          = (state_r == LOCKED);
    assign err_underflow = err_r;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (4 producers, depth 8).
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [15:0] fifo_data_in;
    logic        fifo_wr_en;
    logic        fifo_rd_en;
    logic        fifo_empty;
    logic [3:0]  credits;
    logic        busy;
    logic        err_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        rd;
        logic [3:0]  ready;
        logic        wr;
        logic [15:0] data;
        logic [3:0]  cred;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    fifo_wr_arbiter #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .NUM_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .fifo_data_in(fifo_data_in),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
        .credits(credits), .busy(busy), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Producer i always offers 16'hA5A0 + i.
    assign req_data = {16'hA5A3, 16'hA5A2, 16'hA5A1, 16'hA5A0};

    task automatic add(input logic rst, input logic [3:0] valid, input logic [3:0] last,
                       input logic rd, input logic [3:0] ready, input logic wr,
                       input logic [15:0] data, input logic [3:0] cred,
                       input logic bsy, input logic err);
        vecs[nv] = '{rst, valid, last, rd, ready, wr, data, cred, bsy, err};
        nv++;
    endtask

    task automatic chk(input string name, input int step, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL step %0d %s: got %0h want %0h", step, name, got, want);
        end
    endtask

    initial begin
        // rst valid last rd | ready wr data cred busy err
        add(0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 16'h0000, 4'd8, 0, 0);
        add(0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 16'h0000, 4'd8, 0, 0);
        // round-robin with a pop every cycle once the FIFO holds data
        add(1, 4'b1111, 4'b1111, 0, 4'b0001, 1, 16'hA5A0, 4'd7, 0, 0);
        add(1, 4'b1111, 4'b1111, 1, 4'b0010, 1, 16'hA5A1, 4'd7, 0, 0);
        add(1, 4'b1111, 4'b1111, 1, 4'b0100, 1, 16'hA5A2, 4'd7, 0, 0);
        add(1, 4'b1111, 4'b1111, 1, 4'b1000, 1, 16'hA5A3, 4'd7, 0, 0);
        add(1, 4'b1111, 4'b1111, 1, 4'b0001, 1, 16'hA5A0, 4'd7, 0, 0);
        // producer 2 three-beat packet with a valid gap; others keep requesting
        add(1, 4'b1101, 4'b0000, 0, 4'b0100, 1, 16'hA5A2, 4'd6, 1, 0);
        add(1, 4'b1011, 4'b0000, 0, 4'b0000, 0, 16'hA5A2, 4'd6, 1, 0);
        add(1, 4'b1111, 4'b0000, 0, 4'b0100, 1, 16'hA5A2, 4'd5, 1, 0);
        add(1, 4'b1111, 4'b0100, 0, 4'b0100, 1, 16'hA5A2, 4'd4, 0, 0);
        add(1, 4'b1111, 4'b1111, 0, 4'b1000, 1, 16'hA5A3, 4'd3, 0, 0);
        // accept and pop together at credits 3
        add(1, 4'b0001, 4'b0001, 1, 4'b0001, 1, 16'hA5A0, 4'd3, 0, 0);
        // drain to full credit, then one pop too many
        for (int i = 4; i <= 8; i++)
            add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'hA5A0, 4'(i), 0, 0);
        add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'hA5A0, 4'd8, 0, 1);
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 16'hA5A0, 4'd8, 0, 1);
        // producer 1 streams 10 beats with no pops: only 8 fit
        for (int i = 7; i >= 0; i--)
            add(1, 4'b0010, 4'b0010, 0, 4'b0010, 1, 16'hA5A1, 4'(i), 0, 1);
        add(1, 4'b0010, 4'b0010, 0, 4'b0000, 0, 16'hA5A1, 4'd0, 0, 1);
        add(1, 4'b0010, 4'b0010, 0, 4'b0000, 0, 16'hA5A1, 4'd0, 0, 1);
        add(1, 4'b0010, 4'b0010, 1, 4'b0000, 0, 16'hA5A1, 4'd1, 0, 1);
        add(1, 4'b0010, 4'b0010, 0, 4'b0010, 1, 16'hA5A1, 4'd0, 0, 1);
        add(1, 4'b0010, 4'b0010, 0, 4'b0000, 0, 16'hA5A1, 4'd0, 0, 1);
        // reset in the middle of a producer 3 packet
        add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 16'hA5A1, 4'd1, 0, 1);
        add(1, 4'b1000, 4'b0000, 0, 4'b1000, 1, 16'hA5A3, 4'd0, 1, 1);
        add(0, 4'b1000, 4'b0000, 0, 4'b0000, 0, 16'h0000, 4'd8, 0, 0);
        add(1, 4'b1111, 4'b1111, 0, 4'b0001, 1, 16'hA5A0, 4'd7, 0, 0);

        rst_n = 1'b0; req_valid = '0; req_last = '0; fifo_rd_en = 1'b0; fifo_empty = 1'b1;
        for (int s = 0; s < nv; s++) begin
            @(negedge clk);
            rst_n      = vecs[s].rst;
            req_valid  = vecs[s].valid;
            req_last   = vecs[s].last;
            fifo_rd_en = vecs[s].rd;
            fifo_empty = !vecs[s].rd;
            #1;
            chk("req_ready", s, 32'(req_ready), 32'(vecs[s].ready));
            @(posedge clk);
            #1;
            chk("fifo_wr_en", s, 32'(fifo_wr_en), 32'(vecs[s].wr));
            chk("fifo_data_in", s, 32'(fifo_data_in), 32'(vecs[s].data));
            chk("credits", s, 32'(credits), 32'(vecs[s].cred));
            chk("busy", s, 32'(busy), 32'(vecs[s].busy));
            chk("err_underflow", s, 32'(err_underflow), 32'(vecs[s].err));
        end

        // Sustained one-beat-per-cycle rotation with a steady pop; rr_ptr starts at 1.
        for (int k = 0; k < 8; k++) begin
            logic [1:0] w;
            w = 2'((1 + k) % 4);
            @(negedge clk);
            rst_n = 1'b1; req_valid = 4'b1111; req_last = 4'b1111;
            fifo_rd_en = 1'b1; fifo_empty = 1'b0;
            #1;
            chk("rr_ready", 100 + k, 32'(req_ready), 32'(4'b0001 << w));
            @(posedge clk);
            #1;
            chk("rr_wr_en", 100 + k, 32'(fifo_wr_en), 32'd1);
            chk("rr_data", 100 + k, 32'(fifo_data_in), 32'(16'hA5A0 + 16'(w)));
            chk("rr_credits", 100 + k, 32'(credits), 32'd7);
        end

        @(negedge clk);
        req_valid = '0; fifo_rd_en = 1'b0; fifo_empty = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter and sequencer that lets NUM_REQ producers share one FIFO instance. It sits directly in front of the FIFO's write port and drives `data_in`/`wr_en`. Each producer has a valid/ready handshake. Packets from one producer are delivered contiguously, and producers take turns in round-robin order. A credit counter, fed back from the FIFO read side, guarantees that the FIFO is never written while full.

## Interface
Parameters:
- FIFO_WIDTH, 16, data width; matches the FIFO instance.
- FIFO_DEPTH, 8, FIFO entry count; sets the initial credit count.
- NUM_REQ, 4, number of producers (2..8).

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset. Share it with the FIFO instance.
- req_valid  in  NUM_REQ  per-producer beat valid.
- req_last  in  NUM_REQ  per-producer end-of-packet marker for the current beat.
- req_data  in  NUM_REQ*FIFO_WIDTH  flattened beats; producer i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- req_ready  out  NUM_REQ  per-producer accept; combinational and one-hot or zero.
- fifo_data_in  out  FIFO_WIDTH  registered write data to the FIFO.
- fifo_wr_en  out  1  registered write enable to the FIFO.
- fifo_rd_en  in  1  FIFO read enable, tapped from the consumer.
- fifo_empty  in  1  FIFO empty flag.
- credits  out  $clog2(FIFO_DEPTH+1)  free FIFO entries as seen by the arbiter.
- busy  out  1  high in the LOCKED state.
- err_underflow  out  1  sticky flag: a pop was observed while credits == FIFO_DEPTH.

## Operation
- Accept: producer i's beat is accepted when req_valid[i] && req_ready[i] at a rising edge.
- Pop: a pop is counted when fifo_rd_en && !fifo_empty at a rising edge.
- Credits:
  - accept only: decrement.
  - pop only: increment.
  - accept and pop together: unchanged.
  - A pop while credits == FIFO_DEPTH leaves credits unchanged and sets err_underflow.
- No beat is accepted while credits == 0.

FSM, two states:
- IDLE
  - The winner is the first i with req_valid[i], scanning upward from rr_ptr and wrapping modulo NUM_REQ.
  - req_ready[winner] = (credits != 0).
  - Accepted beat with last=1: stay in IDLE; rr_ptr = winner+1 mod NUM_REQ.
  - Accepted beat with last=0: go to LOCKED; owner = winner.
- LOCKED
  - Only the owner can be ready: req_ready[owner] = req_valid[owner] && credits != 0. All other producers see ready=0.
  - The owner dropping valid mid-packet keeps the lock; the arbiter waits indefinitely.
  - Accepted beat with last=1: go to IDLE; rr_ptr = owner+1 mod NUM_REQ.

Write path:
- On every accept, fifo_data_in <= the accepted beat and fifo_wr_en <= 1.
- Otherwise fifo_wr_en <= 0 and fifo_data_in holds its last value.

## Timing
- Reset values:
  - fifo_wr_en=0, fifo_data_in=0
  - credits=FIFO_DEPTH
  - rr_ptr=0, state IDLE
  - busy=0, err_underflow=0
  - req_ready is all-zero during the reset cycle.
- Latency: a beat accepted at edge t appears on fifo_wr_en/fifo_data_in during the cycle after t and is written into the FIFO at edge t+1.
- Credits update at the accept edge. A full FIFO therefore blocks new accepts even while the last write is still in flight, so FIFO overflow is impossible.
- Back-to-back: one accept per cycle is sustained while credits > 0.
- A pop at edge t frees a credit at edge t. An accept is possible in the cycle after t.
- Reset asserted mid-packet: everything returns to its reset value at the next edge. The partial packet is abandoned, and the FIFO resets on the same edge.
- NUM_REQ not a power of two: rr_ptr wraps from NUM_REQ-1 to 0.

## Test plan
- Reset: drive rst_n=0 for 2 edges with all req_valid=1 -> req_ready=0, fifo_wr_en=0, credits=8, err_underflow=0. After release, producer 0 is granted first.
- Round-robin: all 4 producers assert valid with last=1 continuously; consumer pops every cycle -> grants in order 0,1,2,3,0,1…; FIFO receives one beat per cycle with one cycle of latency.
- Packet lock:
  - Producer 2 sends a 3-beat packet (last on beat 3) while producers 0, 1 and 3 are valid -> only producer 2 is ready until its last beat; busy=1 throughout.
  - Next grant goes to producer 3.
  - A one-cycle valid gap from producer 2 mid-packet does not break the lock.
- Full/credits: no pops; producer 1 streams 10 beats -> exactly 8 accepted, then credits=0 and ready=0. A single pop -> credits=1 and exactly one more accept. The FIFO never asserts overflow.
- Simultaneous accept+pop at credits=3 -> credits stays 3. A forced pop with fifo_empty=0 at credits=8 -> err_underflow=1 and stays set until reset.
- Reset mid-packet: reset during beat 2 of a 4-beat packet -> next cycle state IDLE, busy=0, credits=8, rr_ptr=0.
